// File: rtl/adder_share_ctrl.sv
// Round-robin sequencer sharing one width-bit ripple slice among NREQ requesters.
// Each granted request is a (words*width)-bit add, performed LS word first with a registered carry.
module adder_share_ctrl #(
    parameter int width = 4,
    parameter int words = 4,
    parameter int NREQ  = 2
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [NREQ-1:0]            REQ,
    input  logic [NREQ*words*width-1:0] A_IN,
    input  logic [NREQ*words*width-1:0] B_IN,
    output logic [NREQ-1:0]            GNT,
    output logic [NREQ-1:0]            DONE,
    output logic [words*width:0]       SUM,
    output logic                       BUSY
);

    localparam int OPW = words * width;
    localparam int PW  = $clog2(NREQ);
    localparam int KW  = (words > 1) ? $clog2(words) : 1;

    typedef enum logic [1:0] {IDLE, ADD, FIN} stateT;

    stateT             state, stateNext;
    logic [PW-1:0]     ptr, win, winNext;
    logic              anyReq;
    int unsigned       idx;
    logic [KW-1:0]     k;
    logic              carry, chainCarry, sliceCout;
    logic [OPW-1:0]    opA, opB, res, resNext;
    logic [width-1:0]  sliceA, sliceB, sliceSum;

    // First set request at or after the pointer, wrapping modulo NREQ
    always_comb begin
        anyReq  = 1'b0;
        winNext = '0;
        idx     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!anyReq && REQ[idx[PW-1:0]]) begin
                anyReq  = 1'b1;
                winNext = idx[PW-1:0];
            end
        end
    end

    // Slice of FA cells; carry-in comes from the carry register
    always_comb begin
        sliceA     = opA[k*width +: width];
        sliceB     = opB[k*width +: width];
        sliceSum   = '0;
        chainCarry = carry;
        for (int unsigned b = 0; b < width; b++) begin
            sliceSum[b] = sliceA[b] ^ sliceB[b] ^ chainCarry;
            chainCarry  = (sliceA[b] & sliceB[b]) | (chainCarry & (sliceA[b] ^ sliceB[b]));
        end
        sliceCout = chainCarry;
        resNext   = res;
        resNext[k*width +: width] = sliceSum;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (anyReq) stateNext = ADD;
            ADD:     if (k == KW'(words - 1)) stateNext = FIN;
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            GNT   <= '0;
            SUM   <= '0;
            ptr   <= '0;
            win   <= '0;
            k     <= '0;
            carry <= 1'b0;
            opA   <= '0;
            opB   <= '0;
            res   <= '0;
        end else begin
            case (state)
                IDLE: if (anyReq) begin
                    GNT   <= NREQ'(1) << winNext;
                    win   <= winNext;
                    opA   <= A_IN[winNext*OPW +: OPW];
                    opB   <= B_IN[winNext*OPW +: OPW];
                    k     <= '0;
                    carry <= 1'b0;
                end
                ADD: begin
                    res   <= resNext;
                    carry <= sliceCout;
                    k     <= k + 1'b1;
                    if (k == KW'(words - 1)) SUM <= {sliceCout, resNext};
                end
                FIN: begin
                    GNT <= '0;
                    ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign BUSY = (state != IDLE);
    assign DONE = (state == FIN) ? GNT : '0;

endmodule
